// File: rtl/sc_backg_level_ctrl.sv
// Background-control sequencer: drives the background-type register's clear,
// shift command and level index; scrolls at a level-dependent rate.
module sc_backg_level_ctrl #(
  parameter int unsigned                 PRESCALER_WIDTH = 24,
  parameter logic [PRESCALER_WIDTH-1:0]  PERIOD_LEVEL1   = 24'd12500000,
  parameter logic [PRESCALER_WIDTH-1:0]  PERIOD_LEVEL2   = 24'd10000000,
  parameter logic [PRESCALER_WIDTH-1:0]  PERIOD_LEVEL3   = 24'd7500000,
  parameter logic [PRESCALER_WIDTH-1:0]  PERIOD_LEVEL4   = 24'd5000000,
  parameter logic [1:0]                  SHIFT_DIR       = 2'b01
) (
  input  logic       SC_RegBACKGTYPE_CLOCK_50,
  input  logic       SC_RegBACKGTYPE_RESET_InHigh,
  input  logic       SC_BackgCtrl_start_InLow,
  input  logic       SC_BackgCtrl_levelup_In,
  input  logic       SC_BackgCtrl_lose_In,
  output logic       SC_BackgCtrl_clear_OutLow,
  output logic [1:0] SC_BackgCtrl_shiftselection_Out,
  output logic [2:0] SC_BackgCtrl_transitioncounter_OutBUS,
  output logic       SC_BackgCtrl_win_Out,
  output logic       SC_BackgCtrl_lose_Out
);

  typedef enum logic [2:0] {
    S_INIT, S_WAIT, S_RUN, S_SHIFT, S_LEVELUP, S_END
  } state_t;

  localparam logic [PRESCALER_WIDTH-1:0] P_ONE = {{(PRESCALER_WIDTH-1){1'b0}}, 1'b1};

  state_t                     r_state, w_state_nxt;
  logic [PRESCALER_WIDTH-1:0] r_pre, w_pre_nxt, w_period;
  logic [2:0]                 r_level, w_level_nxt;
  logic                       r_win, w_win_nxt;
  logic                       r_lose, w_lose_nxt;
  logic                       w_expire;

  always_comb begin
    case (r_level[1:0])
      2'd0:    w_period = PERIOD_LEVEL1;
      2'd1:    w_period = PERIOD_LEVEL2;
      2'd2:    w_period = PERIOD_LEVEL3;
      default: w_period = PERIOD_LEVEL4;
    endcase
    w_expire = (r_pre == (w_period - P_ONE));
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pre_nxt   = r_pre;
    w_level_nxt = r_level;
    w_win_nxt   = r_win;
    w_lose_nxt  = r_lose;
    case (r_state)
      S_INIT: begin
        w_level_nxt = '0;
        w_pre_nxt   = '0;
        w_win_nxt   = 1'b0;
        w_lose_nxt  = 1'b0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!SC_BackgCtrl_start_InLow) begin
          w_state_nxt = S_RUN;
          w_pre_nxt   = '0;
        end
      end
      // SHIFT shares RUN's event branches so a pulse landing on the scroll
      // cycle is still honoured, but it never re-triggers a shift.
      S_RUN, S_SHIFT: begin
        if (SC_BackgCtrl_lose_In) begin
          w_state_nxt = S_END;
          w_lose_nxt  = 1'b1;
        end else if (SC_BackgCtrl_levelup_In) begin
          if (r_level < 3'd3) begin
            w_state_nxt = S_LEVELUP;
          end else begin
            w_state_nxt = S_END;
            w_win_nxt   = 1'b1;
          end
        end else if (r_state == S_SHIFT) begin
          w_state_nxt = S_RUN;
          w_pre_nxt   = '0;
        end else if (w_expire) begin
          w_state_nxt = S_SHIFT;
          w_pre_nxt   = '0;
        end else begin
          w_pre_nxt = r_pre + P_ONE;
        end
      end
      S_LEVELUP: begin
        w_level_nxt = (r_level == 3'd3) ? r_level : r_level + 3'd1;
        w_pre_nxt   = '0;
        w_state_nxt = S_RUN;
      end
      S_END: begin
        if (!SC_BackgCtrl_start_InLow) begin
          w_state_nxt = S_INIT;
          w_win_nxt   = 1'b0;
          w_lose_nxt  = 1'b0;
        end
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge SC_RegBACKGTYPE_CLOCK_50 or posedge SC_RegBACKGTYPE_RESET_InHigh) begin
    if (SC_RegBACKGTYPE_RESET_InHigh) begin
      r_state <= S_INIT;
      r_pre   <= '0;
      r_level <= '0;
      r_win   <= 1'b0;
      r_lose  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pre   <= w_pre_nxt;
      r_level <= w_level_nxt;
      r_win   <= w_win_nxt;
      r_lose  <= w_lose_nxt;
    end
  end

  // Outputs are decoded from the present state, so they trail it by one cycle.
  always_ff @(posedge SC_RegBACKGTYPE_CLOCK_50 or posedge SC_RegBACKGTYPE_RESET_InHigh) begin
    if (SC_RegBACKGTYPE_RESET_InHigh) begin
      SC_BackgCtrl_clear_OutLow             <= 1'b0;
      SC_BackgCtrl_shiftselection_Out       <= 2'b00;
      SC_BackgCtrl_transitioncounter_OutBUS <= 3'd0;
      SC_BackgCtrl_win_Out                  <= 1'b0;
      SC_BackgCtrl_lose_Out                 <= 1'b0;
    end else begin
      SC_BackgCtrl_clear_OutLow             <= (r_state != S_INIT);
      SC_BackgCtrl_shiftselection_Out       <= (r_state == S_SHIFT) ? SHIFT_DIR : 2'b00;
      SC_BackgCtrl_transitioncounter_OutBUS <= r_level;
      SC_BackgCtrl_win_Out                  <= r_win;
      SC_BackgCtrl_lose_Out                 <= r_lose;
    end
  end

endmodule

// File: doc/sc_backg_level_ctrl.md
Name: sc_backg_level_ctrl

Overview:
Background-control sequencer that sits directly upstream of the background-type register.
- Generates the register's clear strobe, its 2-bit shift-selection command and its 3-bit level (transition) counter.
- Scrolls the lane pattern at a level-dependent rate and advances levels when the frog reaches the far bank.
- Ends the game on a win after level 4 or on a loss.

Parameters:
- PRESCALER_WIDTH, 24, width of the scroll-period counter.
- PERIOD_LEVEL1, 24'd12500000, clock cycles between scroll steps in level 1.
- PERIOD_LEVEL2, 24'd10000000, scroll period in level 2.
- PERIOD_LEVEL3, 24'd7500000, scroll period in level 3.
- PERIOD_LEVEL4, 24'd5000000, scroll period in level 4.
- SHIFT_DIR, 2'b01, shift command issued on each scroll step (01 = rotate left, 10 = rotate right).

Ports:
- SC_RegBACKGTYPE_CLOCK_50  input  1  system clock, 50 MHz.
- SC_RegBACKGTYPE_RESET_InHigh  input  1  asynchronous, active-high reset.
- SC_BackgCtrl_start_InLow  input  1  start/restart request, active low, level-sampled.
- SC_BackgCtrl_levelup_In  input  1  one-cycle pulse: frog reached the far bank.
- SC_BackgCtrl_lose_In  input  1  one-cycle pulse: frog died.
- SC_BackgCtrl_clear_OutLow  output  1  clear to the background register, active low.
- SC_BackgCtrl_shiftselection_Out  output  2  shift command to the background register.
- SC_BackgCtrl_transitioncounter_OutBUS  output  3  current level index 0..3.
- SC_BackgCtrl_win_Out  output  1  high while in END after a win.
- SC_BackgCtrl_lose_Out  output  1  high while in END after a loss.

Behaviour:
- Reset: SC_RegBACKGTYPE_CLOCK_50 rising edge is the only clock; reset SC_RegBACKGTYPE_RESET_InHigh is asynchronous, active-high. Reset takes effect immediately, including mid-scroll or mid-level.
  - State = INIT, prescaler = 0, level = 3'd0.
  - clear_OutLow = 0, shiftselection = 2'b00, win = 0, lose = 0.
- All outputs are registered (Moore). Values appear one cycle after the state/counter update that causes them.
- FSM states and transitions:
  - INIT: clear_OutLow = 0, level <= 0, prescaler <= 0, win/lose <= 0. Unconditionally -> WAIT next cycle.
  - WAIT: clear_OutLow = 1, shiftselection = 00. If start_InLow == 0 -> RUN with prescaler <= 0.
  - RUN: prescaler increments each cycle. Event priority is lose_In > levelup_In > period expiry.
    - lose_In = 1 -> END with lose flag set.
    - levelup_In = 1 and level < 3 -> LEVELUP.
    - levelup_In = 1 and level == 3 -> END with win flag set.
    - prescaler == PERIOD_LEVELn - 1 (n = level + 1) -> SHIFT with prescaler <= 0.
  - SHIFT: lasts exactly one cycle; shiftselection = SHIFT_DIR.
    - Returns to RUN; the prescaler restarts counting from 0.
    - lose_In or levelup_In arriving in this cycle is still honoured: it takes the same branch RUN would take, and the shift pulse is not repeated.
  - LEVELUP: lasts one cycle; level <= level + 1, prescaler <= 0, shiftselection = 00 -> RUN. The new level's period applies from the first RUN cycle.
  - END: shiftselection = 00; level and the win/lose flags hold. start_InLow == 0 -> INIT, which gives a one-cycle clear pulse followed by a fresh game.
- shiftselection is 2'b00 in every state except SHIFT, so exactly one non-zero cycle per scroll step.
- Level counter: saturates at 3 and never wraps; bit 2 is always 0.
- Prescaler compare is against the period of the current level. If a level change shortens the period below the current count, the prescaler was already zeroed in LEVELUP, so no overrun is possible.
- levelup_In and lose_In are ignored in INIT, WAIT and END.
- win_Out and lose_Out are mutually exclusive, and both are 0 outside END.

Test Plan:
1. Reset asserted mid-RUN at level 2 -> outputs immediately show level 0, clear_OutLow 0, shift 00; after release: one cycle INIT, then WAIT with clear_OutLow 1.
2. PERIOD_LEVEL1..4 = 4,3,2,1; start_InLow low one cycle -> in level 0, a single shiftselection=01 pulse every 5 cycles (4 RUN + 1 SHIFT), 00 otherwise.
3. levelup_In pulsed 3 times with 10-cycle gaps -> transitioncounter steps 0→1→2→3. Scroll pulse spacing becomes 4, 3, then 2 cycles respectively.
4. At level 3, pulse levelup_In -> END with win_Out=1 and transitioncounter held at 3; shift pulses stop; start_InLow low -> one clear pulse, then level 0.
5. lose_In and levelup_In asserted in the same cycle as period expiry at level 1 -> END with lose_Out=1, level stays 1, no shift pulse emitted.
6. SHIFT_DIR=2'b10 build -> every scroll pulse reads 2'b10; levelup_In asserted during a SHIFT cycle -> next state LEVELUP, single shift pulse only.
